// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with an IDLE/EXEC controller.
// Single-cycle add/sub/and/or/xor, one-bit-per-cycle logical shifts and an
// optional iterative shift-add multiplier (one multiplier bit per cycle).
// Compile-time option: define ALU_SEQ_MUL_EN to build the multiplier for
// op 7; without it op 7 finishes in one clock with a zero result.
// Reset is synchronous and active-low; all outputs are registered.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   op,
    output logic [n-1:0] r,
    output logic         N,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         busy,
    output logic         done
);

    localparam int SW = $clog2(n);   // shift-amount width
    localparam int CW = SW + 1;      // step counter must hold the value n

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t          state_q;
    logic [n-1:0]    a_q;
    logic [n-1:0]    b_q;
    logic [2:0]      op_q;
    logic [n-1:0]    acc_q;          // shift working register
    logic [n-1:0]    acc_d;
    logic [CW-1:0]   cnt_q;          // EXEC steps still to run
    logic [CW-1:0]   cnt_d;

`ifdef ALU_SEQ_MUL_EN
    logic [2*n-1:0]  prod_q;         // {partial product, remaining multiplier bits}
    logic [2*n-1:0]  prod_d;
    logic [n:0]      sum_s;
`endif

    logic            fin_s;          // this EXEC step is the last one
    logic [n-1:0]    res_s;
    logic            c_s;
    logic            v_s;

    // One EXEC step: next working state plus the result/flags if this step finishes
    always_comb begin
        fin_s = 1'b1;
        res_s = {n{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        acc_d = acc_q;
        cnt_d = cnt_q;
`ifdef ALU_SEQ_MUL_EN
        prod_d = prod_q;
        sum_s  = {(n+1){1'b0}};
`endif
        case (op_q)
            3'd0: begin
                {c_s, res_s} = {1'b0, a_q} + {1'b0, b_q};
                v_s = (a_q[n-1] == b_q[n-1]) && (res_s[n-1] != a_q[n-1]);
            end
            3'd1: begin
                // subtraction as a + ~b + 1 so the carry means "no borrow"
                {c_s, res_s} = {1'b0, a_q} + {1'b0, ~b_q} + {{n{1'b0}}, 1'b1};
                v_s = (a_q[n-1] != b_q[n-1]) && (res_s[n-1] != a_q[n-1]);
            end
            3'd2: begin
                if (cnt_q == {CW{1'b0}}) begin
                    res_s = acc_q;
                    c_s   = 1'b0;
                end else begin
                    res_s = {1'b0, acc_q[n-1:1]};
                    c_s   = acc_q[0];
                    fin_s = (cnt_q == CW'(1));
                    acc_d = res_s;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            3'd3: begin
                if (cnt_q == {CW{1'b0}}) begin
                    res_s = acc_q;
                    c_s   = 1'b0;
                end else begin
                    res_s = {acc_q[n-2:0], 1'b0};
                    c_s   = acc_q[n-1];
                    fin_s = (cnt_q == CW'(1));
                    acc_d = res_s;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            3'd4: res_s = a_q & b_q;
            3'd5: res_s = a_q | b_q;
            3'd6: res_s = a_q ^ b_q;
            3'd7: begin
`ifdef ALU_SEQ_MUL_EN
                if (prod_q[0]) begin
                    sum_s = {1'b0, prod_q[2*n-1:n]} + {1'b0, a_q};
                end else begin
                    sum_s = {1'b0, prod_q[2*n-1:n]};
                end
                prod_d = {sum_s, prod_q[n-1:1]};
                fin_s  = (cnt_q == CW'(1));
                cnt_d  = cnt_q - CW'(1);
                res_s  = prod_d[n-1:0];
                c_s    = |prod_d[2*n-1:n];
                v_s    = c_s;
`else
                res_s = {n{1'b0}};
`endif
            end
            default: res_s = {n{1'b0}};
        endcase
    end

    // Controller: capture in IDLE, iterate in EXEC, publish result/flags on the final step
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= {n{1'b0}};
            b_q     <= {n{1'b0}};
            op_q    <= 3'd0;
            acc_q   <= {n{1'b0}};
            cnt_q   <= {CW{1'b0}};
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= {(2*n){1'b0}};
`endif
            r       <= {n{1'b0}};
            N       <= 1'b0;
            Z       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        acc_q  <= a;
`ifdef ALU_SEQ_MUL_EN
                        prod_q <= {{n{1'b0}}, b};
`endif
                        if (op == 3'd2 || op == 3'd3) begin
                            cnt_q <= {1'b0, b[SW-1:0]};
                        end else if (op == 3'd7) begin
                            cnt_q <= CW'(n);
                        end else begin
                            cnt_q <= CW'(1);
                        end
                        busy    <= 1'b1;
                        state_q <= EXEC;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
                    prod_q <= prod_d;
`endif
                    if (fin_s) begin
                        r       <= res_s;
                        N       <= res_s[n-1];
                        Z       <= (res_s == {n{1'b0}});
                        C       <= c_s;
                        V       <= v_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed + random self-checking bench for alu_seq (n = 8).
// Expected results come from an arithmetic reference model and travel through
// a scoreboard queue from the start pulse to the done pulse.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int NW = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] a     = '0;
    logic [NW-1:0] b     = '0;
    logic [2:0]    op    = 3'd0;
    logic [NW-1:0] r;
    logic          N, Z, C, V, busy, done;

    always #5 clk = ~clk;

    alu_seq #(.n(NW)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .op   (op),
        .r    (r),
        .N    (N),
        .Z    (Z),
        .C    (C),
        .V    (V),
        .busy (busy),
        .done (done)
    );

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;      // {N,Z,C,V}
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_r = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ua, ub, sa, sb, res, sr, s;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        s  = ub % 8;
        e.lat = 1;
        e.r = 8'h00;
        e.f = 4'h0;
        res = 0;
        sr  = 0;
        case (o)
            3'd0: begin
                res = ua + ub; e.r = res[7:0]; e.f[1] = (res > 255);
                sr = sa + sb;  e.f[0] = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                res = ua - ub; e.r = res[7:0]; e.f[1] = (ua >= ub);
                sr = sa - sb;  e.f[0] = (sr > 127) || (sr < -128);
            end
            3'd2: begin
                res = ua >> s; e.r = res[7:0];
                e.f[1] = (s == 0) ? 1'b0 : (((ua >> (s - 1)) & 1) != 0);
                e.lat = (s == 0) ? 1 : s;
            end
            3'd3: begin
                res = ua << s; e.r = res[7:0];
                e.f[1] = (s == 0) ? 1'b0 : (((ua >> (8 - s)) & 1) != 0);
                e.lat = (s == 0) ? 1 : s;
            end
            3'd4: e.r = x & y;
            3'd5: e.r = x | y;
            3'd6: e.r = x ^ y;
            default: begin
`ifdef ALU_SEQ_MUL_EN
                res = ua * ub; e.r = res[7:0];
                e.f[1] = ((res >> 8) != 0);
                e.f[0] = e.f[1];
                e.lat = 8;
`else
                e.r = 8'h00;
`endif
            end
        endcase
        e.f[3] = e.r[7];
        e.f[2] = (e.r == 8'h00);
        return e;
    endfunction

    // Issue one operation, optionally poke start while busy, then check the completion
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit inject);
        exp_t e;
        int   lat;
        op = o; a = x; b = y; start = 1'b1;
        sb_q.push_back(model(o, x, y));
        tick;
        start = 1'b0;
        check($sformatf("op%0d_busy_after_start", o), {31'd0, busy}, 32'd1);
        check($sformatf("op%0d_done_one_cycle", o), {31'd0, done}, 32'd0);
        check($sformatf("op%0d_r_hold", o), {24'd0, r}, {24'd0, last_r});
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (inject && lat == 1) begin
                start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick;
            lat++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check($sformatf("op%0d_done_seen", o), {31'd0, done}, 32'd1);
        check($sformatf("op%0d_busy_in_done", o), {31'd0, busy}, 32'd0);
        check($sformatf("op%0d_r a=%0h b=%0h", o, x, y), {24'd0, r}, {24'd0, e.r});
        check($sformatf("op%0d_NZCV a=%0h b=%0h", o, x, y), {28'd0, N, Z, C, V}, {28'd0, e.f});
        check($sformatf("op%0d_latency", o), lat, e.lat);
        last_r = e.r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_done;
        // reset with start held high: start must be ignored
        rst = 1'b0; start = 1'b1; op = 3'd0; a = 8'h12; b = 8'h34;
        tick;
        tick;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_r", {24'd0, r}, 32'd0);
        check("rst_NZCV", {28'd0, N, Z, C, V}, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        tick;
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        // directed cases, issued back-to-back on the done cycle
        run_op(3'd0, 8'h7F, 8'h01, 1'b0);
        run_op(3'd1, 8'h05, 8'h05, 1'b0);
        run_op(3'd1, 8'h03, 8'h05, 1'b0);
        run_op(3'd3, 8'h81, 8'h03, 1'b0);
        run_op(3'd2, 8'h81, 8'h00, 1'b0);
        run_op(3'd7, 8'h10, 8'h20, 1'b0);
        run_op(3'd7, 8'h0C, 8'h0B, 1'b1);
        run_op(3'd0, 8'hFF, 8'h01, 1'b0);
        run_op(3'd1, 8'h80, 8'h01, 1'b0);
        run_op(3'd2, 8'hF0, 8'h0F, 1'b1);
        run_op(3'd3, 8'h01, 8'h08, 1'b0);
        run_op(3'd3, 8'hC3, 8'h07, 1'b1);
        run_op(3'd4, 8'hF0, 8'h3C, 1'b0);
        run_op(3'd5, 8'h00, 8'h00, 1'b0);
        run_op(3'd6, 8'hA5, 8'h5A, 1'b0);
        tick;

        // random operations
        for (int i = 0; i < 16; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // reset in the 4th busy cycle of a long operation aborts it
        run_op(3'd0, 8'h11, 8'h22, 1'b0);
`ifdef ALU_SEQ_MUL_EN
        op = 3'd7; a = 8'h0C; b = 8'h0B;
`else
        op = 3'd3; a = 8'hFF; b = 8'h07;
`endif
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_r", {24'd0, r}, 32'd0);
        check("abort_NZCV", {28'd0, N, Z, C, V}, 32'd0);
        rst = 1'b1;
        last_r = 8'h00;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);

        // recovery after abort
        run_op(3'd6, 8'hA5, 8'h0F, 1'b0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter n, default 8, meaning operand/result width in bits (n >= 4, power of two).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning reset; reset is synchronous and active-low (rst=0 sampled at rising clk edge resets the block).
REQ-004 The block SHALL have port start, input, 1 bit, meaning request to capture a, b and op.
REQ-005 The block SHALL have ports a and b, input, n bits each, meaning operands.
REQ-006 The block SHALL have port op, input, 3 bits, meaning operation: 0 add, 1 sub, 2 shift right, 3 shift left, 4 and, 5 or, 6 xor, 7 mul.
REQ-007 The block SHALL have port r, output, n bits, meaning registered result.
REQ-008 The block SHALL have ports N, Z, C, V, output, 1 bit each, meaning registered negative, zero, carry and overflow flags.
REQ-009 The block SHALL have ports busy and done, output, 1 bit each, meaning operation in progress and one-cycle completion pulse.

Function
REQ-010 The FSM SHALL have states IDLE and EXEC; IDLE with start=1 captures a, b and op into internal registers, then moves to EXEC; the final EXEC step returns to IDLE.
REQ-011 busy SHALL be 1 exactly while in EXEC; start SHALL be ignored while busy=1.
REQ-012 On the final EXEC step r and N/Z/C/V SHALL update together and done SHALL be 1 for exactly the following cycle; r and flags hold their values until the next completion.
REQ-013 Latency from capture edge to result edge SHALL be 1 clock for ops 0,1,4,5,6; max(1,s) clocks for shifts; n clocks for mul.
REQ-014 start=1 in the cycle done=1 SHALL be accepted (back-to-back operations, one idle cycle between).
REQ-015 add: r = (a+b) mod 2^n; C = carry-out; V = signed overflow.
REQ-016 sub: r = (a-b) mod 2^n computed as a+~b+1; C = carry-out of that sum (1 when a >= b unsigned); V = signed overflow.
REQ-017 Shifts: amount s = b[log2(n)-1:0]; logical, zero fill; one bit per EXEC cycle; C = last bit shifted out (0 when s=0); V=0.
REQ-018 and/or/xor: bitwise on a, b; C=0, V=0.
REQ-019 mul: unsigned iterative shift-add, one multiplier bit per cycle; r = low n bits of a*b; C = V = 1 if high n bits nonzero, else 0.
REQ-020 For every op N = r[n-1] and Z = (r == 0).

Reset
REQ-021 With rst=0 at a rising edge, state SHALL go to IDLE and r, N, Z, C, V, busy, done SHALL all be 0, including mid-operation (operation aborted, no done pulse).
REQ-022 start asserted in the same cycle as rst=0 SHALL be ignored.

Configuration
REQ-023 Macro ALU_SEQ_MUL_EN defined: op 7 SHALL behave per REQ-019.
REQ-024 Macro ALU_SEQ_MUL_EN undefined: no multiplier logic; op 7 SHALL complete in 1 clock with r=0, Z=1, N=C=V=0.

Verification (n=8)
REQ-025 start, op=0, a=0x7F, b=0x01 -> 1 clock later r=0x80, N=1, Z=0, C=0, V=1, done pulse 1 cycle.
REQ-026 start, op=1, a=0x05, b=0x05 -> r=0x00, Z=1, C=1, N=0, V=0 after 1 clock; op=1, a=0x03, b=0x05 -> r=0xFE, N=1, C=0.
REQ-027 start, op=3, a=0x81, b=0x03 -> busy 3 cycles, r=0x08, C=0, done on 4th cycle; op=2, a=0x81, b=0x00 -> r=0x81, C=0 after 1 clock.
REQ-028 start, op=7, a=0x10, b=0x20 (MUL_EN) -> busy 8 cycles, r=0x00, Z=1, C=1, V=1; a=0x0C, b=0x0B -> r=0x84, N=1, C=0.
REQ-029 start pulsed again during mul busy with op=0 -> ignored, mul result unchanged; start during done cycle -> accepted.
REQ-030 rst=0 at 4th cycle of a mul -> next cycle busy=0, done=0, r=0, all flags 0; no done pulse follows.
